// File: rtl/status_array_arbiter_pkg.sv
// status_array_arbiter_pkg
// -------------------------------------------------------------------------
// Shared widths, state encodings and helpers for the status array arbiter
// slice. Imported by status_array_arbiter and status_arb_rsp_pipe.
//
// Contents:
//   ARB_ADDR_WIDTH  - status array row address width (6)
//   ARB_ROW_WIDTH   - status row width in bits (8)
//   ARB_NUM_BLOCKS  - blocks per row, one write-mask bit each (4)
//   STAT_WIDTH      - width of the optional request statistics counters
//   arbState_e      - arbiter FSM states (INIT = 0, RUN = 1)
//   satIncrement    - saturating increment used by the statistics counters
// -------------------------------------------------------------------------
package status_array_arbiter_pkg;

   localparam int ARB_ADDR_WIDTH = 6;
   localparam int ARB_ROW_WIDTH  = 8;
   localparam int ARB_NUM_BLOCKS = 4;
   localparam int STAT_WIDTH     = 16;

   // INIT owns the SRAM on behalf of the initializer; RUN serves the
   // cache controller. The encoding matches the rest of the status array.
   typedef enum logic [0:0] {
      ARB_STATE_INIT = 1'b0,
      ARB_STATE_RUN  = 1'b1
   } arbState_e;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [STAT_WIDTH-1:0] satIncrement(input logic [STAT_WIDTH-1:0] value);
      return (value == '1) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/status_array_arbiter_rsp_pipe.sv
// status_arb_rsp_pipe
// -------------------------------------------------------------------------
// Read response pipeline for the status array arbiter. A read issued to the
// SRAM is tracked by a two-entry shift register of flags; when a flag leaves
// the second entry the SRAM read data is valid and is captured into the
// response register together with a one-cycle valid strobe.
//
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset, clears all flags/outputs
//   i_halt       - freeze: all registers hold while high
//   i_rd_issue   - a client read was accepted this cycle
//   i_mem_rdata  - SRAM read data (valid the cycle after the read is sampled)
//   o_rsp_data   - captured read data, holds when no response is strobed
//   o_rsp_valid  - one-cycle read response strobe
// -------------------------------------------------------------------------
module status_arb_rsp_pipe
   import status_array_arbiter_pkg::*;
#(
   parameter int ROW_WIDTH = ARB_ROW_WIDTH
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_halt,
   input  logic                 i_rd_issue,
   input  logic [ROW_WIDTH-1:0] i_mem_rdata,
   output logic [ROW_WIDTH-1:0] o_rsp_data,
   output logic                 o_rsp_valid
);

   logic [1:0]           rdFlag_q;
   logic [1:0]           rdFlag_d;
   logic                 rspValid_q;
   logic                 rspValid_d;
   logic [ROW_WIDTH-1:0] rspData_q;
   logic [ROW_WIDTH-1:0] rspData_d;

   // Entry 0 marks a read command now on the SRAM pins, entry 1 marks a read
   // whose data is on i_mem_rdata. Everything holds while halted so an
   // in-flight read resumes exactly where it stopped.
   always_comb begin
      rdFlag_d   = rdFlag_q;
      rspValid_d = rspValid_q;
      rspData_d  = rspData_q;
      if (!i_halt) begin
         rdFlag_d   = {rdFlag_q[0], i_rd_issue};
         rspValid_d = rdFlag_q[1];
         if (rdFlag_q[1]) begin
            rspData_d = i_mem_rdata;
         end
      end
   end

   // Reset discards any read in flight so it never produces a response.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdFlag_q   <= '0;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
      end else begin
         rdFlag_q   <= rdFlag_d;
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
      end
   end

   assign o_rsp_data  = rspData_q;
   assign o_rsp_valid = rspValid_q;

endmodule

// File: rtl/status_array_arbiter.sv
// status_array_arbiter
// -------------------------------------------------------------------------
// Arbitrates the status array SRAM between the power-up initializer and the
// cache controller. In INIT only initializer writes reach the SRAM; once the
// initializer reports completion the arbiter moves to RUN for good and
// serves controller reads/writes over a valid/ready port, one per cycle,
// with pipelined read responses two edges after acceptance.
// All SRAM command outputs are registered.
//
// Optional feature (macro STATUS_ARB_STATS_EN):
//   adds o_stat_reads / o_stat_writes, 16-bit saturating counters of
//   accepted RUN-state client reads and writes.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_halt            - freeze: no state, counter or output register updates
//   i_init_*          - initializer command port (addr/data/wen/wmask/valid)
//   i_init_complete   - initializer finished
//   i_req_*           - client request port (addr/data/wen/wmask/valid)
//   o_req_ready       - client request accepted when valid & ready
//   o_rsp_data/valid  - read response data and one-cycle strobe
//   o_mem_*           - registered SRAM command (addr/data/wen/wmask/cen)
//   i_mem_rdata       - SRAM read data, valid the cycle after a read
//   o_busy_init       - high while in INIT
//   o_stat_reads/writes - request statistics (STATUS_ARB_STATS_EN only)
// -------------------------------------------------------------------------
module status_array_arbiter
   import status_array_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
   parameter int NUM_BLOCKS = ARB_NUM_BLOCKS,
   parameter int ROW_WIDTH  = ARB_ROW_WIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_halt,
   input  logic [ADDR_WIDTH-1:0] i_init_addr,
   input  logic [ROW_WIDTH-1:0]  i_init_data,
   input  logic                  i_init_wen,
   input  logic [NUM_BLOCKS-1:0] i_init_wmask,
   input  logic                  i_init_valid,
   input  logic                  i_init_complete,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [ROW_WIDTH-1:0]  i_req_data,
   input  logic                  i_req_wen,
   input  logic [NUM_BLOCKS-1:0] i_req_wmask,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   output logic [ROW_WIDTH-1:0]  o_rsp_data,
   output logic                  o_rsp_valid,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [ROW_WIDTH-1:0]  o_mem_data,
   output logic                  o_mem_wen,
   output logic [NUM_BLOCKS-1:0] o_mem_wmask,
   output logic                  o_mem_cen,
   input  logic [ROW_WIDTH-1:0]  i_mem_rdata,
   output logic                  o_busy_init
`ifdef STATUS_ARB_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] o_stat_reads,
   output logic [STAT_WIDTH-1:0] o_stat_writes
`endif
);

   arbState_e             state_q;
   arbState_e             state_d;
   logic [ADDR_WIDTH-1:0] memAddr_q;
   logic [ADDR_WIDTH-1:0] memAddr_d;
   logic [ROW_WIDTH-1:0]  memData_q;
   logic [ROW_WIDTH-1:0]  memData_d;
   logic [NUM_BLOCKS-1:0] memWmask_q;
   logic [NUM_BLOCKS-1:0] memWmask_d;
   logic                  memWen_q;
   logic                  memWen_d;
   logic                  memCen_q;
   logic                  memCen_d;
   logic                  reqAccept;
   logic                  rdIssue;

   // The client port is only open in RUN, and closes combinationally during
   // a halt so nothing is accepted while the registers are frozen.
   always_comb begin
      o_req_ready = (state_q == ARB_STATE_RUN) && !i_halt;
      reqAccept   = i_req_valid && o_req_ready;
      rdIssue     = reqAccept && !i_req_wen;
   end

   // Next-state and SRAM command selection. A halt freezes everything,
   // including a command already on the SRAM pins. Otherwise the chip enable
   // is a pulse per forwarded command, while address/data/mask keep their
   // last values when idle. An initializer write that arrives together with
   // completion is still forwarded and delays RUN by one cycle.
   always_comb begin
      state_d    = state_q;
      memAddr_d  = memAddr_q;
      memData_d  = memData_q;
      memWmask_d = memWmask_q;
      memWen_d   = memWen_q;
      memCen_d   = memCen_q;
      if (!i_halt) begin
         memCen_d = 1'b0;
         memWen_d = 1'b0;
         case (state_q)
            ARB_STATE_INIT: begin
               if (i_init_valid) begin
                  memCen_d   = 1'b1;
                  memWen_d   = i_init_wen;
                  memAddr_d  = i_init_addr;
                  memData_d  = i_init_data;
                  memWmask_d = i_init_wmask;
               end else if (i_init_complete) begin
                  state_d = ARB_STATE_RUN;
               end
            end
            ARB_STATE_RUN: begin
               if (reqAccept) begin
                  memCen_d  = 1'b1;
                  memAddr_d = i_req_addr;
                  if (i_req_wen) begin
                     memWen_d   = 1'b1;
                     memData_d  = i_req_data;
                     memWmask_d = i_req_wmask;
                  end else begin
                     memWen_d   = 1'b0;
                     memData_d  = '0;
                     memWmask_d = '0;
                  end
               end
            end
            default: begin
               state_d = ARB_STATE_INIT;
            end
         endcase
      end
   end

   // State and SRAM command registers; reset returns to INIT with the SRAM
   // interface idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_STATE_INIT;
         memAddr_q  <= '0;
         memData_q  <= '0;
         memWmask_q <= '0;
         memWen_q   <= 1'b0;
         memCen_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         memAddr_q  <= memAddr_d;
         memData_q  <= memData_d;
         memWmask_q <= memWmask_d;
         memWen_q   <= memWen_d;
         memCen_q   <= memCen_d;
      end
   end

   assign o_mem_addr  = memAddr_q;
   assign o_mem_data  = memData_q;
   assign o_mem_wmask = memWmask_q;
   assign o_mem_wen   = memWen_q;
   assign o_mem_cen   = memCen_q;
   assign o_busy_init = (state_q == ARB_STATE_INIT);

   // Read responses come back through a short flag pipeline that lines the
   // SRAM read latency up with the response strobe.
   status_arb_rsp_pipe #(
      .ROW_WIDTH (ROW_WIDTH)
   ) u_rsp_pipe (
      .clk         (clk),
      .rst         (rst),
      .i_halt      (i_halt),
      .i_rd_issue  (rdIssue),
      .i_mem_rdata (i_mem_rdata),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_valid (o_rsp_valid)
   );

`ifdef STATUS_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] statReads_q;
   logic [STAT_WIDTH-1:0] statReads_d;
   logic [STAT_WIDTH-1:0] statWrites_q;
   logic [STAT_WIDTH-1:0] statWrites_d;

   // Only client requests accepted in RUN are counted; reqAccept already
   // excludes INIT and halted cycles, so init writes never show up here.
   always_comb begin
      statReads_d  = statReads_q;
      statWrites_d = statWrites_q;
      if (reqAccept) begin
         if (i_req_wen) begin
            statWrites_d = satIncrement(statWrites_q);
         end else begin
            statReads_d = satIncrement(statReads_q);
         end
      end
   end

   // Counter registers, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         statReads_q  <= '0;
         statWrites_q <= '0;
      end else begin
         statReads_q  <= statReads_d;
         statWrites_q <= statWrites_d;
      end
   end

   assign o_stat_reads  = statReads_q;
   assign o_stat_writes = statWrites_q;
`endif

endmodule

// File: tb/tb_status_array_arbiter.sv
// tb_status_array_arbiter
// -------------------------------------------------------------------------
// Self-checking bench for status_array_arbiter. Includes a behavioural SRAM
// (write-first across cycles, 2 bits per write-mask block, read data one
// cycle after the command is sampled). Covers reset, the 64-row init sweep,
// a table of RUN-state commands and responses, halt with a read in flight,
// reset with a read in flight and, with STATUS_ARB_STATS_EN, counter
// saturation.
// -------------------------------------------------------------------------
module tb_status_array_arbiter;

   logic       clk;
   logic       rst;
   logic       i_halt;
   logic [5:0] i_init_addr;
   logic [7:0] i_init_data;
   logic       i_init_wen;
   logic [3:0] i_init_wmask;
   logic       i_init_valid;
   logic       i_init_complete;
   logic [5:0] i_req_addr;
   logic [7:0] i_req_data;
   logic       i_req_wen;
   logic [3:0] i_req_wmask;
   logic       i_req_valid;
   logic       o_req_ready;
   logic [7:0] o_rsp_data;
   logic       o_rsp_valid;
   logic [5:0] o_mem_addr;
   logic [7:0] o_mem_data;
   logic       o_mem_wen;
   logic [3:0] o_mem_wmask;
   logic       o_mem_cen;
   logic [7:0] i_mem_rdata;
   logic       o_busy_init;
`ifdef STATUS_ARB_STATS_EN
   logic [15:0] o_stat_reads;
   logic [15:0] o_stat_writes;
`endif

   int errCount   = 0;
   int checkCount = 0;

   status_array_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .i_halt          (i_halt),
      .i_init_addr     (i_init_addr),
      .i_init_data     (i_init_data),
      .i_init_wen      (i_init_wen),
      .i_init_wmask    (i_init_wmask),
      .i_init_valid    (i_init_valid),
      .i_init_complete (i_init_complete),
      .i_req_addr      (i_req_addr),
      .i_req_data      (i_req_data),
      .i_req_wen       (i_req_wen),
      .i_req_wmask     (i_req_wmask),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .o_rsp_data      (o_rsp_data),
      .o_rsp_valid     (o_rsp_valid),
      .o_mem_addr      (o_mem_addr),
      .o_mem_data      (o_mem_data),
      .o_mem_wen       (o_mem_wen),
      .o_mem_wmask     (o_mem_wmask),
      .o_mem_cen       (o_mem_cen),
      .i_mem_rdata     (i_mem_rdata),
      .o_busy_init     (o_busy_init)
`ifdef STATUS_ARB_STATS_EN
      ,
      .o_stat_reads    (o_stat_reads),
      .o_stat_writes   (o_stat_writes)
`endif
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural SRAM. While reset is held it is filled with a non-zero
   // pattern so that the init sweep visibly clears it.
   logic [7:0] sramMem [64];
   always @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < 64; a++) begin
            sramMem[a] <= 8'h80 | 8'(a);
         end
      end else if (o_mem_cen) begin
         if (o_mem_wen) begin
            for (int b = 0; b < 4; b++) begin
               if (o_mem_wmask[b]) begin
                  sramMem[o_mem_addr][2*b +: 2] <= o_mem_data[2*b +: 2];
               end
            end
         end else begin
            i_mem_rdata <= sramMem[o_mem_addr];
         end
      end
   end

   typedef struct {
      logic       reqValid;
      logic       reqWen;
      logic [5:0] reqAddr;
      logic [7:0] reqData;
      logic [3:0] reqWmask;
      logic       halt;
      logic       expReady;
      logic       expCen;
      logic       expWen;
      logic [5:0] expAddr;
      logic [7:0] expData;
      logic [3:0] expWmask;
      logic       expRspValid;
      logic [7:0] expRspData;
   } vec_t;

   vec_t vecs [14];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic wen, input logic [5:0] addr,
                                input logic [7:0] data, input logic [3:0] mask, input logic halt);
      i_req_valid = valid;
      i_req_wen   = wen;
      i_req_addr  = addr;
      i_req_data  = data;
      i_req_wmask = mask;
      i_halt      = halt;
   endtask

   initial begin
      int cenCount;
      int rspCount;
      logic readySeen;
      logic [7:0] lastRsp;

      rst             = 1'b1;
      i_init_addr     = '0;
      i_init_data     = '0;
      i_init_wen      = 1'b0;
      i_init_wmask    = '0;
      i_init_valid    = 1'b0;
      i_init_complete = 1'b0;
      applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 4'h0, 1'b0);

      // RUN-state command table: inputs, then registered SRAM command and
      // response expected after the following edge.
      vecs[0]  = '{1'b1, 1'b1, 6'd5, 8'hA5, 4'b0011, 1'b0,  1'b1, 1'b1, 1'b1, 6'd5, 8'hA5, 4'b0011, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 6'd5, 8'h77, 4'b1111, 1'b0,  1'b1, 1'b1, 1'b0, 6'd5, 8'h00, 4'b0000, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 1'b1, 6'd9, 8'hEE, 4'b1111, 1'b0,  1'b1, 1'b0, 1'b0, 6'd5, 8'h00, 4'b0000, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 1'b1, 6'd1, 8'h3C, 4'b1111, 1'b0,  1'b1, 1'b1, 1'b1, 6'd1, 8'h3C, 4'b1111, 1'b1, 8'h05};
      vecs[4]  = '{1'b1, 1'b1, 6'd2, 8'hC3, 4'b1100, 1'b0,  1'b1, 1'b1, 1'b1, 6'd2, 8'hC3, 4'b1100, 1'b0, 8'h05};
      vecs[5]  = '{1'b1, 1'b1, 6'd3, 8'hFF, 4'b0101, 1'b0,  1'b1, 1'b1, 1'b1, 6'd3, 8'hFF, 4'b0101, 1'b0, 8'h05};
      vecs[6]  = '{1'b1, 1'b1, 6'd7, 8'h11, 4'b1111, 1'b1,  1'b0, 1'b1, 1'b1, 6'd3, 8'hFF, 4'b0101, 1'b0, 8'h05};
      vecs[7]  = '{1'b0, 1'b0, 6'd0, 8'h00, 4'b0000, 1'b0,  1'b1, 1'b0, 1'b0, 6'd3, 8'hFF, 4'b0101, 1'b0, 8'h05};
      vecs[8]  = '{1'b1, 1'b0, 6'd1, 8'hAA, 4'b1111, 1'b0,  1'b1, 1'b1, 1'b0, 6'd1, 8'h00, 4'b0000, 1'b0, 8'h05};
      vecs[9]  = '{1'b1, 1'b0, 6'd2, 8'h00, 4'b0000, 1'b0,  1'b1, 1'b1, 1'b0, 6'd2, 8'h00, 4'b0000, 1'b0, 8'h05};
      vecs[10] = '{1'b1, 1'b0, 6'd3, 8'h00, 4'b0000, 1'b0,  1'b1, 1'b1, 1'b0, 6'd3, 8'h00, 4'b0000, 1'b1, 8'h3C};
      vecs[11] = '{1'b0, 1'b0, 6'd0, 8'h00, 4'b0000, 1'b0,  1'b1, 1'b0, 1'b0, 6'd3, 8'h00, 4'b0000, 1'b1, 8'hC0};
      vecs[12] = '{1'b0, 1'b0, 6'd0, 8'h00, 4'b0000, 1'b0,  1'b1, 1'b0, 1'b0, 6'd3, 8'h00, 4'b0000, 1'b1, 8'h33};
      vecs[13] = '{1'b0, 1'b0, 6'd0, 8'h00, 4'b0000, 1'b0,  1'b1, 1'b0, 1'b0, 6'd3, 8'h00, 4'b0000, 1'b0, 8'h33};

      // ---- reset state ----
      repeat (3) @(negedge clk);
      checkOutput("reset busy_init", 32'(o_busy_init), 32'd1);
      checkOutput("reset req_ready", 32'(o_req_ready), 32'd0);
      checkOutput("reset mem_cen",   32'(o_mem_cen),   32'd0);
      checkOutput("reset mem_wen",   32'(o_mem_wen),   32'd0);
      checkOutput("reset mem_addr",  32'(o_mem_addr),  32'd0);
      checkOutput("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
      checkOutput("reset rsp_data",  32'(o_rsp_data),  32'd0);
      rst = 1'b0;

      // ---- init sweep: 64 writes, complete alongside the last one ----
      $display("[TB] init sweep");
      cenCount  = 0;
      readySeen = 1'b0;
      applyStimulus(1'b1, 1'b0, 6'd9, 8'h00, 4'h0, 1'b0);
      for (int i = 0; i < 64; i++) begin
         i_init_valid    = 1'b1;
         i_init_wen      = 1'b1;
         i_init_addr     = 6'(i);
         i_init_data     = 8'h00;
         i_init_wmask    = 4'hF;
         i_init_complete = (i == 63);
         #1 readySeen |= o_req_ready;
         @(negedge clk);
         if (o_mem_cen && o_mem_wen) cenCount++;
      end
      checkOutput("init busy after last write", 32'(o_busy_init), 32'd1);
      checkOutput("init last addr",  32'(o_mem_addr),  32'd63);
      checkOutput("init last wmask", 32'(o_mem_wmask), 32'hF);
      i_init_valid = 1'b0;
      applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 4'h0, 1'b0);
      #1 readySeen |= o_req_ready;
      @(negedge clk);
      if (o_mem_cen && o_mem_wen) cenCount++;
      checkOutput("init cen pulses",    32'(cenCount),   32'd64);
      checkOutput("init ready seen",    32'(readySeen),  32'd0);
      checkOutput("run busy_init",      32'(o_busy_init), 32'd0);
      checkOutput("run mem_cen idle",   32'(o_mem_cen),  32'd0);

      // ---- RUN command table ----
      $display("[TB] run table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].reqValid, vecs[i].reqWen, vecs[i].reqAddr,
                       vecs[i].reqData, vecs[i].reqWmask, vecs[i].halt);
         #1 checkOutput($sformatf("vec%0d req_ready", i), 32'(o_req_ready), 32'(vecs[i].expReady));
         @(negedge clk);
         checkOutput($sformatf("vec%0d mem_cen", i),   32'(o_mem_cen),   32'(vecs[i].expCen));
         checkOutput($sformatf("vec%0d mem_wen", i),   32'(o_mem_wen),   32'(vecs[i].expWen));
         checkOutput($sformatf("vec%0d mem_addr", i),  32'(o_mem_addr),  32'(vecs[i].expAddr));
         checkOutput($sformatf("vec%0d mem_data", i),  32'(o_mem_data),  32'(vecs[i].expData));
         checkOutput($sformatf("vec%0d mem_wmask", i), 32'(o_mem_wmask), 32'(vecs[i].expWmask));
         checkOutput($sformatf("vec%0d rsp_valid", i), 32'(o_rsp_valid), 32'(vecs[i].expRspValid));
         checkOutput($sformatf("vec%0d rsp_data", i),  32'(o_rsp_data),  32'(vecs[i].expRspData));
      end

      // ---- halt for 3 cycles with a read of addr 2 in flight ----
      $display("[TB] halt with read in flight");
      applyStimulus(1'b1, 1'b0, 6'd2, 8'h00, 4'h0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 4'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput($sformatf("halt%0d req_ready", i), 32'(o_req_ready), 32'd0);
         @(negedge clk);
         checkOutput($sformatf("halt%0d mem_cen", i),   32'(o_mem_cen),   32'd1);
         checkOutput($sformatf("halt%0d mem_addr", i),  32'(o_mem_addr),  32'd2);
         checkOutput($sformatf("halt%0d rsp_valid", i), 32'(o_rsp_valid), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 4'h0, 1'b0);
      rspCount = 0;
      lastRsp  = 8'h00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (o_rsp_valid) begin
            rspCount++;
            lastRsp = o_rsp_data;
         end
      end
      checkOutput("halt response count", 32'(rspCount), 32'd1);
      checkOutput("halt response data",  32'(lastRsp),  32'hC0);

      // ---- reset the cycle after a read accept ----
      $display("[TB] reset with read in flight");
      applyStimulus(1'b1, 1'b0, 6'd1, 8'h00, 4'h0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 4'h0, 1'b0);
      i_init_complete = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rspCount = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (o_rsp_valid) rspCount++;
      end
      checkOutput("rst-in-flight rsp count", 32'(rspCount),    32'd0);
      checkOutput("rst-in-flight busy_init", 32'(o_busy_init), 32'd1);
      checkOutput("rst-in-flight req_ready", 32'(o_req_ready), 32'd0);
      checkOutput("rst-in-flight mem_cen",   32'(o_mem_cen),   32'd0);

`ifdef STATUS_ARB_STATS_EN
      // ---- statistics saturation ----
      $display("[TB] statistics saturation");
      i_init_complete = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("stats run entered", 32'(o_busy_init), 32'd0);
      for (int i = 0; i < 70000; i++) begin
         applyStimulus(1'b1, 1'b1, 6'(i), 8'(i), 4'hF, 1'b0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 6'd0, 8'h00, 4'h0, 1'b0);
      @(negedge clk);
      checkOutput("stats writes saturated", 32'(o_stat_writes), 32'hFFFF);
      checkOutput("stats reads zero",       32'(o_stat_reads),  32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
